// File: rtl/axi_wr_burst_gen_if.sv
// axi_wr_burst_gen_if
// Write-address, write-data and write-response signals between the burst
// generator (master modport) and the downstream AXI write-channel FSM
// (slave modport).
//   AW channel : awaddr_out, awlen_out, awsize_out, awburst_out, awvalid_out / awready_in
//   W channel  : wdata_out, wstrb_out, wlast_out, wvalid_out / wready_in
//   B channel  : bvalid_in, bresp_in / bready_out
interface axi_wr_burst_gen_if #(
  parameter int AW = 32,
  parameter int DW = 64
);
  logic [AW-1:0] awaddr_out;
  logic [7:0]    awlen_out;
  logic [2:0]    awsize_out;
  logic [1:0]    awburst_out;
  logic          awvalid_out;
  logic          awready_in;
  logic [DW-1:0] wdata_out;
  logic [7:0]    wstrb_out;
  logic          wlast_out;
  logic          wvalid_out;
  logic          wready_in;
  logic          bvalid_in;
  logic [1:0]    bresp_in;
  logic          bready_out;

  modport master (
    output awaddr_out, awlen_out, awsize_out, awburst_out, awvalid_out,
    input  awready_in,
    output wdata_out, wstrb_out, wlast_out, wvalid_out,
    input  wready_in,
    input  bvalid_in, bresp_in,
    output bready_out
  );

  modport slave (
    input  awaddr_out, awlen_out, awsize_out, awburst_out, awvalid_out,
    output awready_in,
    input  wdata_out, wstrb_out, wlast_out, wvalid_out,
    output wready_in,
    output bvalid_in, bresp_in,
    input  bready_out
  );
endinterface

// File: rtl/axi_wr_burst_gen.sv
// axi_wr_burst_gen
// Accepts one write-burst command at a time, issues the AW beat, streams
// len+1 patterned W beats (beat k carries seed+k) with lane-correct strobes,
// collects the B response and reports done/err/timeout as one-cycle pulses.
// Ports:
//   axi_aclk, axi_areset        clock, asynchronous active-high reset
//   cmd_valid/cmd_ready         command handshake (ready only while idle)
//   cmd_addr/len/size/burst     burst description, latched on accept
//   cmd_seed                    data of beat 0
//   axi                         AW/W/B channel bundle (master side)
//   done, err, timeout          end-of-command pulse and its qualifiers
module axi_wr_burst_gen #(
  parameter int AW        = 32,
  parameter int DW        = 64,
  parameter int B_TIMEOUT = 256
) (
  input  logic               axi_aclk,
  input  logic               axi_areset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [AW-1:0]      cmd_addr,
  input  logic [7:0]         cmd_len,
  input  logic [2:0]         cmd_size,
  input  logic [1:0]         cmd_burst,
  input  logic [DW-1:0]      cmd_seed,
  axi_wr_burst_gen_if.master axi,
  output logic               done,
  output logic               err,
  output logic               timeout
);
  localparam int CW = (B_TIMEOUT > 1) ? $clog2(B_TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, BADCMD} state_t;

  state_t        state_reg, state_next;
  logic          cmd_ready_reg, cmd_ready_next;
  logic [AW-1:0] awaddr_reg, awaddr_next;
  logic [7:0]    awlen_reg, awlen_next;
  logic [2:0]    awsize_reg, awsize_next;
  logic [1:0]    awburst_reg, awburst_next;
  logic          awvalid_reg, awvalid_next;
  logic [AW-1:0] beat_addr_reg, beat_addr_next;
  logic [8:0]    beat_cnt_reg, beat_cnt_next;
  logic [DW-1:0] wdata_reg, wdata_next;
  logic [7:0]    wstrb_reg, wstrb_next;
  logic          wlast_reg, wlast_next;
  logic          wvalid_reg, wvalid_next;
  logic          bready_reg, bready_next;
  logic [CW-1:0] resp_cnt_reg, resp_cnt_next;
  logic          done_reg, done_next;
  logic          err_reg, err_next;
  logic          timeout_reg, timeout_next;
  logic          cmd_bad;
  logic [AW-1:0] step_addr;

  // Byte lanes touched by a beat of 2^size bytes at the given low address
  // bits; the lane offset is rounded down to the transfer size.
  function automatic logic [7:0] beat_strb(input logic [2:0] a_lo, input logic [2:0] size);
    logic [3:0]  nbytes;
    logic [15:0] lanes;
    logic [15:0] shifted;
    logic [2:0]  lo;
    nbytes  = 4'd1 << size;
    lanes   = (16'd1 << nbytes) - 16'd1;
    lo      = a_lo & ~(nbytes[2:0] - 3'd1);
    shifted = lanes << lo;
    return shifted[7:0];
  endfunction

  // Address of the following beat. WRAP keeps the upper bits of the
  // (len+1)<<size window and lets only the offset inside it roll over.
  function automatic logic [AW-1:0] next_beat_addr(input logic [AW-1:0] a, input logic [7:0] len,
                                                   input logic [2:0] size, input logic [1:0] burst);
    logic [AW-1:0] incr;
    logic [AW-1:0] wrap_mask;
    logic [AW-1:0] stepped;
    logic [AW-1:0] result;
    incr      = AW'(1) << size;
    wrap_mask = (AW'({1'b0, len} + 9'd1) << size) - AW'(1);
    stepped   = a + incr;
    case (burst)
      2'b00:   result = a;
      2'b10:   result = (a & ~wrap_mask) | (stepped & wrap_mask);
      default: result = stepped;
    endcase
    return result;
  endfunction

  assign cmd_bad = (cmd_size > 3'd3) || (cmd_burst == 2'b11) ||
                   ((cmd_burst == 2'b10) && !((cmd_len == 8'd1) || (cmd_len == 8'd3) ||
                                              (cmd_len == 8'd7) || (cmd_len == 8'd15)));

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state_reg     <= IDLE;
      cmd_ready_reg <= 1'b0;
      awaddr_reg    <= '0;
      awlen_reg     <= '0;
      awsize_reg    <= '0;
      awburst_reg   <= '0;
      awvalid_reg   <= 1'b0;
      beat_addr_reg <= '0;
      beat_cnt_reg  <= '0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      wlast_reg     <= 1'b0;
      wvalid_reg    <= 1'b0;
      bready_reg    <= 1'b0;
      resp_cnt_reg  <= '0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cmd_ready_reg <= cmd_ready_next;
      awaddr_reg    <= awaddr_next;
      awlen_reg     <= awlen_next;
      awsize_reg    <= awsize_next;
      awburst_reg   <= awburst_next;
      awvalid_reg   <= awvalid_next;
      beat_addr_reg <= beat_addr_next;
      beat_cnt_reg  <= beat_cnt_next;
      wdata_reg     <= wdata_next;
      wstrb_reg     <= wstrb_next;
      wlast_reg     <= wlast_next;
      wvalid_reg    <= wvalid_next;
      bready_reg    <= bready_next;
      resp_cnt_reg  <= resp_cnt_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
      timeout_reg   <= timeout_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    awaddr_next    = awaddr_reg;
    awlen_next     = awlen_reg;
    awsize_next    = awsize_reg;
    awburst_next   = awburst_reg;
    awvalid_next   = awvalid_reg;
    beat_addr_next = beat_addr_reg;
    beat_cnt_next  = beat_cnt_reg;
    wdata_next     = wdata_reg;
    wstrb_next     = wstrb_reg;
    wlast_next     = wlast_reg;
    wvalid_next    = wvalid_reg;
    bready_next    = bready_reg;
    resp_cnt_next  = resp_cnt_reg;
    done_next      = 1'b0;
    err_next       = 1'b0;
    timeout_next   = 1'b0;
    step_addr      = next_beat_addr(beat_addr_reg, awlen_reg, awsize_reg, awburst_reg);

    case (state_reg)
      IDLE: begin
        if (cmd_valid && cmd_ready_reg) begin
          if (cmd_bad) begin
            state_next = BADCMD;
          end else begin
            state_next     = ADDR;
            awaddr_next    = cmd_addr;
            awlen_next     = cmd_len;
            awsize_next    = cmd_size;
            awburst_next   = cmd_burst;
            awvalid_next   = 1'b1;
            beat_addr_next = cmd_addr;
            beat_cnt_next  = '0;
            wdata_next     = cmd_seed;
            wstrb_next     = beat_strb(cmd_addr[2:0], cmd_size);
            wlast_next     = (cmd_len == 8'd0);
          end
        end
      end
      ADDR: begin
        if (axi.awready_in) begin
          awvalid_next = 1'b0;
          wvalid_next  = 1'b1;
          state_next   = DATA;
        end
      end
      DATA: begin
        // Beat registers only move on a handshake, so they hold while stalled.
        if (wvalid_reg && axi.wready_in) begin
          if (wlast_reg) begin
            wvalid_next   = 1'b0;
            bready_next   = 1'b1;
            resp_cnt_next = '0;
            state_next    = RESP;
          end else begin
            beat_cnt_next  = beat_cnt_reg + 9'd1;
            beat_addr_next = step_addr;
            wdata_next     = wdata_reg + DW'(1);
            wstrb_next     = beat_strb(step_addr[2:0], awsize_reg);
            wlast_next     = ((beat_cnt_reg + 9'd1) == {1'b0, awlen_reg});
          end
        end
      end
      RESP: begin
        if (axi.bvalid_in && bready_reg) begin
          done_next   = 1'b1;
          err_next    = (axi.bresp_in != 2'b00);
          bready_next = 1'b0;
          state_next  = IDLE;
        end else if (resp_cnt_reg == CW'(B_TIMEOUT - 1)) begin
          done_next    = 1'b1;
          err_next     = 1'b1;
          timeout_next = 1'b1;
          bready_next  = 1'b0;
          state_next   = IDLE;
        end else begin
          resp_cnt_next = resp_cnt_reg + CW'(1);
        end
      end
      BADCMD: begin
        done_next  = 1'b1;
        err_next   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Registered ready: goes high the cycle the FSM lands back in IDLE.
    cmd_ready_next = (state_next == IDLE);
  end

  assign cmd_ready       = cmd_ready_reg;
  assign axi.awaddr_out  = awaddr_reg;
  assign axi.awlen_out   = awlen_reg;
  assign axi.awsize_out  = awsize_reg;
  assign axi.awburst_out = awburst_reg;
  assign axi.awvalid_out = awvalid_reg;
  assign axi.wdata_out   = wdata_reg;
  assign axi.wstrb_out   = wstrb_reg;
  assign axi.wlast_out   = wlast_reg;
  assign axi.wvalid_out  = wvalid_reg;
  assign axi.bready_out  = bready_reg;
  assign done            = done_reg;
  assign err             = err_reg;
  assign timeout         = timeout_reg;
endmodule

// File: tb/tb_axi_wr_burst_gen.sv
`timescale 1ns/1ps
module tb_axi_wr_burst_gen;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int B_TIMEOUT = 256;

  logic          axi_aclk = 1'b0;
  logic          axi_areset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic [2:0]    cmd_size;
  logic [1:0]    cmd_burst;
  logic [DW-1:0] cmd_seed;
  logic          done;
  logic          err;
  logic          timeout;

  int vectors = 0;
  int miscompares = 0;
  int txn = 0;

  axi_wr_burst_gen_if #(.AW(AW), .DW(DW)) bus ();

  axi_wr_burst_gen #(.AW(AW), .DW(DW), .B_TIMEOUT(B_TIMEOUT)) dut (
    .axi_aclk   (axi_aclk),
    .axi_areset (axi_areset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .cmd_size   (cmd_size),
    .cmd_burst  (cmd_burst),
    .cmd_seed   (cmd_seed),
    .axi        (bus),
    .done       (done),
    .err        (err),
    .timeout    (timeout)
  );

  always #5 axi_aclk = ~axi_aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: address and strobe of beat k from the burst rules.
  function automatic logic [31:0] exp_addr(input logic [31:0] start, input int len, input int size,
                                           input int burst, input int k);
    int          bytes;
    logic [31:0] wrap;
    logic [31:0] base;
    bytes = 1 << size;
    case (burst)
      0: return start;
      2: begin
        wrap = 32'((len + 1) * bytes);
        base = start - (start % wrap);
        return base + (((start - base) + 32'(k * bytes)) % wrap);
      end
      default: return start + 32'(k * bytes);
    endcase
  endfunction

  function automatic logic [7:0] exp_strb(input logic [31:0] addr, input int size);
    int         bytes;
    int         lo;
    logic [7:0] s;
    bytes = 1 << size;
    lo    = (int'(addr % 8) / bytes) * bytes;
    s     = 8'h00;
    for (int i = lo; i < lo + bytes; i++) s[i] = 1'b1;
    return s;
  endfunction

  task automatic check_all_zero(input string tag);
    chk_eq({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(0));
    chk_eq({tag, "_awvalid"}, 64'(bus.awvalid_out), 64'(0));
    chk_eq({tag, "_awaddr"}, 64'(bus.awaddr_out), 64'(0));
    chk_eq({tag, "_awlen"}, 64'(bus.awlen_out), 64'(0));
    chk_eq({tag, "_wvalid"}, 64'(bus.wvalid_out), 64'(0));
    chk_eq({tag, "_wdata"}, 64'(bus.wdata_out), 64'(0));
    chk_eq({tag, "_wstrb"}, 64'(bus.wstrb_out), 64'(0));
    chk_eq({tag, "_wlast"}, 64'(bus.wlast_out), 64'(0));
    chk_eq({tag, "_bready"}, 64'(bus.bready_out), 64'(0));
    chk_eq({tag, "_done"}, 64'({done, err, timeout}), 64'(0));
  endtask

  // Issue one command and follow it to completion (or to a reset abort).
  // ready_mode 0: awready/wready always 1; 1: random.
  task automatic run_cmd(input logic [31:0] a, input int len, input int size, input int burst,
                         input logic [63:0] seed, input int bresp, input int ready_mode,
                         input int stall_beat, input int stall_len, input bit no_bvalid,
                         input int abort_beat);
    bit bad;
    int phase;
    int beat;
    int rc;
    int stall_cnt;
    int bdelay;
    int hs;
    bit aw_hs;
    bit w_hs;
    bit b_hs;
    logic [31:0] ba;
    logic [2:0] res;

    bad = (size > 3) || (burst == 3) ||
          ((burst == 2) && !((len == 1) || (len == 3) || (len == 7) || (len == 15)));
    for (int i = 0; i < 50 && cmd_ready !== 1'b1; i++) begin
      @(posedge axi_aclk); #1;
    end
    chk_eq("cmd_ready_idle", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = 8'(len);
    cmd_size  = 3'(size);
    cmd_burst = 2'(burst);
    cmd_seed  = seed;
    @(posedge axi_aclk); #1;
    cmd_valid = 1'b0;
    cmd_addr  = $urandom;
    cmd_len   = 8'($urandom);
    cmd_size  = 3'($urandom);
    cmd_burst = 2'($urandom);
    cmd_seed  = {$urandom, $urandom};
    chk_eq("cmd_ready_drop", 64'(cmd_ready), 64'(0));

    if (bad) begin
      chk_eq("bad_awvalid", 64'(bus.awvalid_out), 64'(0));
      chk_eq("bad_done_early", 64'(done), 64'(0));
      @(posedge axi_aclk); #1;
      chk_eq("bad_done", 64'(done), 64'(1));
      chk_eq("bad_err", 64'(err), 64'(1));
      chk_eq("bad_timeout", 64'(timeout), 64'(0));
      chk_eq("bad_awvalid2", 64'(bus.awvalid_out), 64'(0));
      chk_eq("bad_wvalid", 64'(bus.wvalid_out), 64'(0));
      res = {done, err, timeout};
      @(posedge axi_aclk); #1;
      chk_eq("bad_done_pulse", 64'(done), 64'(0));
      $display("txn %0d addr=%h len=%0d size=%0d burst=%0d rejected done/err/to=%b",
               txn, a, len, size, burst, res);
      txn++;
      return;
    end

    phase     = 0;
    beat      = 0;
    rc        = 0;
    stall_cnt = 0;
    hs        = 0;
    bdelay    = $urandom_range(0, 4);
    for (int cyc = 0; cyc < 3000 && phase < 3; cyc++) begin
      aw_hs = 1'b0;
      w_hs  = 1'b0;
      b_hs  = 1'b0;
      chk_eq("done_early", 64'(done), 64'(0));
      case (phase)
        0: begin
          chk_eq("awvalid", 64'(bus.awvalid_out), 64'(1));
          chk_eq("awaddr", 64'(bus.awaddr_out), 64'(a));
          chk_eq("awlen", 64'(bus.awlen_out), 64'(len));
          chk_eq("awsize", 64'(bus.awsize_out), 64'(size));
          chk_eq("awburst", 64'(bus.awburst_out), 64'(burst));
          chk_eq("wvalid_in_aw", 64'(bus.wvalid_out), 64'(0));
          bus.awready_in = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
          bus.wready_in  = 1'($urandom_range(0, 1));
          aw_hs = bus.awready_in;
        end
        1: begin
          if (beat == abort_beat) begin
            axi_areset = 1'b1;
            #1;
            check_all_zero("abort");
            @(posedge axi_aclk); #1;
            axi_areset = 1'b0;
            chk_eq("abort_ready_low", 64'(cmd_ready), 64'(0));
            @(posedge axi_aclk); #1;
            chk_eq("abort_ready_back", 64'(cmd_ready), 64'(1));
            chk_eq("abort_no_done", 64'(done), 64'(0));
            $display("txn %0d addr=%h len=%0d aborted by reset at beat %0d", txn, a, len, beat);
            txn++;
            return;
          end
          ba = exp_addr(a, len, size, burst, beat);
          chk_eq("wvalid", 64'(bus.wvalid_out), 64'(1));
          chk_eq("wdata", bus.wdata_out, seed + 64'(beat));
          chk_eq("wstrb", 64'(bus.wstrb_out), 64'(exp_strb(ba, size)));
          chk_eq("wlast", 64'(bus.wlast_out), 64'(beat == len));
          chk_eq("awvalid_in_w", 64'(bus.awvalid_out), 64'(0));
          chk_eq("bready_in_w", 64'(bus.bready_out), 64'(0));
          bus.awready_in = 1'($urandom_range(0, 1));
          if (beat == stall_beat && stall_cnt < stall_len) begin
            bus.wready_in = 1'b0;
            stall_cnt++;
          end else begin
            bus.wready_in = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
          end
          w_hs = bus.wready_in;
        end
        default: begin
          rc++;
          chk_eq("bready", 64'(bus.bready_out), 64'(1));
          chk_eq("wvalid_in_b", 64'(bus.wvalid_out), 64'(0));
          bus.wready_in = 1'($urandom_range(0, 1));
          bus.bvalid_in = no_bvalid ? 1'b0 : (rc > bdelay);
          bus.bresp_in  = 2'(bresp);
          b_hs = bus.bvalid_in;
        end
      endcase
      if (phase != 2) begin
        bus.bvalid_in = 1'($urandom_range(0, 1));
        bus.bresp_in  = 2'($urandom);
      end
      @(posedge axi_aclk); #1;
      if (aw_hs) phase = 1;
      if (w_hs) begin
        hs++;
        if (beat == len) phase = 2;
        else beat++;
      end
      if (b_hs || (no_bvalid && rc == B_TIMEOUT)) phase = 3;
    end

    chk_eq("completed_in_budget", 64'(phase), 64'(3));
    chk_eq("w_handshakes", 64'(hs), 64'(len + 1));
    chk_eq("done", 64'(done), 64'(1));
    chk_eq("err", 64'(err), 64'(no_bvalid ? 1 : (bresp != 0)));
    chk_eq("timeout", 64'(timeout), 64'(no_bvalid));
    chk_eq("bready_after", 64'(bus.bready_out), 64'(0));
    res = {done, err, timeout};
    bus.awready_in = 1'b0;
    bus.wready_in  = 1'b0;
    bus.bvalid_in  = 1'b0;
    @(posedge axi_aclk); #1;
    chk_eq("done_pulse", 64'(done), 64'(0));
    $display("txn %0d addr=%h len=%0d size=%0d burst=%0d beats=%0d resp_cycles=%0d done/err/to=%b",
             txn, a, len, size, burst, hs, rc, res);
    txn++;
  endtask

  initial begin
    int sz;
    int bu;
    int ln;
    int wl;
    axi_areset     = 1'b1;
    cmd_valid      = 1'b0;
    cmd_addr       = '0;
    cmd_len        = '0;
    cmd_size       = '0;
    cmd_burst      = '0;
    cmd_seed       = '0;
    bus.awready_in = 1'b0;
    bus.wready_in  = 1'b0;
    bus.bvalid_in  = 1'b0;
    bus.bresp_in   = 2'b00;
    repeat (3) @(posedge axi_aclk);
    #1;
    check_all_zero("reset");
    axi_areset = 1'b0;
    chk_eq("ready_after_release", 64'(cmd_ready), 64'(0));
    @(posedge axi_aclk); #1;
    chk_eq("ready_first", 64'(cmd_ready), 64'(1));

    // T1 .. T6 directed cases
    run_cmd(32'h1000, 0, 3, 1, 64'hA5, 0, 0, -1, 0, 1'b0, -1);
    run_cmd(32'h1004, 3, 2, 1, 64'h10, 0, 0, -1, 0, 1'b0, -1);
    run_cmd(32'h1004, 3, 2, 1, 64'h10, 0, 0, 1, 5, 1'b0, -1);
    run_cmd(32'h2000, 1, 3, 1, 64'h77, 2, 0, -1, 0, 1'b0, -1);
    run_cmd(32'h2000, 0, 3, 1, 64'h78, 0, 0, -1, 0, 1'b1, -1);
    run_cmd(32'h3000, 3, 2, 3, 64'h1, 0, 0, -1, 0, 1'b0, -1);
    run_cmd(32'h3000, 3, 4, 1, 64'h1, 0, 0, -1, 0, 1'b0, -1);
    run_cmd(32'h3000, 2, 2, 2, 64'h1, 0, 0, -1, 0, 1'b0, -1);
    run_cmd(32'h1000, 3, 3, 1, 64'h55, 0, 0, -1, 0, 1'b0, 2);
    run_cmd(32'h1000, 0, 3, 1, 64'hA5, 0, 0, -1, 0, 1'b0, -1);
    // Address-rule boundaries: wrap windows, fixed narrow, seed rollover, long burst
    run_cmd(32'h38, 3, 3, 2, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, -1, 0, 1'b0, -1);
    run_cmd(32'h0C, 3, 2, 2, 64'h100, 1, 1, -1, 0, 1'b0, -1);
    run_cmd(32'h06, 2, 1, 0, 64'h200, 3, 1, -1, 0, 1'b0, -1);
    run_cmd(32'h4001, 15, 0, 2, 64'h300, 0, 1, -1, 0, 1'b0, -1);
    run_cmd(32'h5000, 255, 3, 1, 64'h400, 0, 0, -1, 0, 1'b0, -1);

    for (int n = 0; n < 40; n++) begin
      sz = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
      bu = $urandom_range(0, 3);
      if (bu == 2) begin
        wl = $urandom_range(0, 4);
        ln = (wl == 4) ? $urandom_range(0, 20) : ((2 << wl) - 1);
      end else begin
        ln = $urandom_range(0, 20);
      end
      run_cmd($urandom, ln, sz, bu, {$urandom, $urandom}, $urandom_range(0, 3), 1,
              $urandom_range(0, 3), $urandom_range(0, 4), ($urandom_range(0, 19) == 0), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
